// File: rtl/bit_flip_locator_if.sv
// Request/result bundle for bit_flip_locator: start + operand pair in, busy/done/index/error out.
// Ports: i_start, i_a, i_b (requester -> locator); o_busy, o_done, o_idx, o_ERR (locator -> requester).
// master = requester side, slave = locator side.
interface bit_flip_locator_if #(
    parameter int N = 8
);
    logic         i_start;
    logic [N-1:0] i_a;
    logic [N-1:0] i_b;
    logic         o_busy;
    logic         o_done;
    logic [N-1:0] o_idx;
    logic         o_ERR;

    modport master (
        output i_start, i_a, i_b,
        input  o_busy, o_done, o_idx, o_ERR
    );

    modport slave (
        input  i_start, i_a, i_b,
        output o_busy, o_done, o_idx, o_ERR
    );
endinterface

// File: rtl/bit_flip_locator.sv
// Purpose: finds the single differing bit between i_a and i_b by serial scan, one bit per clock.
// Latency: o_done in the cycle after edge N+1 from start (earlier on a second hit when early exit is on).
// Backpressure: none; i_start is only honoured in IDLE, o_busy high while a scan/result is pending.
// Ports: i_clk, i_rst (sync, active-high); bus (slave modport): i_start/i_a/i_b in,
//        o_busy/o_done/o_idx/o_ERR out. o_idx is sign-magnitude with sign bit always 0.
// Optional macro LOCATOR_EARLY_EXIT_EN: a second differing bit ends the scan early with o_ERR=1.
module bit_flip_locator #(
    parameter int N = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    bit_flip_locator_if.slave bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  diff_q, diff_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] pos_q, pos_d;
    logic [1:0]    hits_q, hits_d;
    // fin: all bits examined (or early exit); the following cycle registers the result.
    logic          fin_q, fin_d;
    logic [N-1:0]  idx_q, idx_d;
    logic          err_q, err_d;

    logic          cur_bit;

    assign cur_bit = diff_q[cnt_q];

    always_comb begin
        state_d = state_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        pos_d   = pos_q;
        hits_d  = hits_q;
        fin_d   = fin_q;
        idx_d   = idx_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = SCAN;
                    diff_d  = bus.i_a ^ bus.i_b;
                    cnt_d   = '0;
                    hits_d  = '0;
                    fin_d   = 1'b0;
                end
            end
            SCAN: begin
                if (fin_q) begin
                    state_d = DONE;
                    fin_d   = 1'b0;
                    if (hits_q == 2'd1) begin
                        idx_d = {{(N-CW){1'b0}}, pos_q};
                        err_d = 1'b0;
                    end else begin
                        idx_d = '0;
                        err_d = 1'b1;
                    end
                end else begin
                    if (cur_bit) begin
                        if (hits_q == 2'd0) begin
                            pos_d = cnt_q;
                        end
                        // Saturate at 2: anything beyond one hit is just "too many".
                        hits_d = (hits_q == 2'd2) ? 2'd2 : hits_q + 2'd1;
                    end
                    if (cnt_q == CW'(N-1)) begin
                        fin_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
`ifdef LOCATOR_EARLY_EXIT_EN
                    if (cur_bit && (hits_q == 2'd1)) begin
                        fin_d = 1'b1;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            diff_q  <= '0;
            cnt_q   <= '0;
            pos_q   <= '0;
            hits_q  <= '0;
            fin_q   <= 1'b0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            pos_q   <= pos_d;
            hits_q  <= hits_d;
            fin_q   <= fin_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign bus.o_busy = (state_q != IDLE);
    assign bus.o_done = (state_q == DONE);
    assign bus.o_idx  = idx_q;
    assign bus.o_ERR  = err_q;
endmodule

// File: tb/tb_bit_flip_locator.sv
module tb_bit_flip_locator;
    localparam int N = 8;
`ifdef LOCATOR_EARLY_EXIT_EN
    localparam int DBL_EDGE   = 3;  // a=00 b=03: second hit at bit 1
    localparam int TRIPLE_EDGE = 8; // a=00 b=E0: second hit at bit 6
`else
    localparam int DBL_EDGE   = 9;
    localparam int TRIPLE_EDGE = 9;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bit_flip_locator_if #(.N(N)) bus ();

    bit_flip_locator #(.N(N)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Issues one start at edge 0 and watches 14 edges. Optionally re-pulses i_start
    // before edge restart_edge with other operands. Reports the first o_done edge,
    // the number of o_done cycles seen, and the result captured at the first o_done.
    task automatic run_scan(input logic [N-1:0] a, input logic [N-1:0] b,
                            input int restart_edge, input logic [N-1:0] ra, input logic [N-1:0] rb,
                            output int done_edge, output int done_cnt,
                            output logic [N-1:0] idx, output logic err);
        done_edge = -1;
        done_cnt  = 0;
        idx       = 'x;
        err       = 1'bx;
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_a     = a;
        bus.i_b     = b;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_a     = ~a;
        bus.i_b     = b ^ 8'hFF;
        for (int e = 1; e <= 14; e++) begin
            if (e == restart_edge) begin
                bus.i_start = 1'b1;
                bus.i_a     = ra;
                bus.i_b     = rb;
            end
            @(posedge clk);
            #1;
            bus.i_start = 1'b0;
            if (bus.o_done === 1'b1) begin
                done_cnt++;
                if (done_edge < 0) begin
                    done_edge = e;
                    idx       = bus.o_idx;
                    err       = bus.o_ERR;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
        checks++;
        if (bus.o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.o_done); end
        checks++;
        if (bus.o_idx !== 8'h00 || bus.o_ERR !== 1'b0) begin
            failures++; $display("FAIL reset_result got idx=%h err=%b exp idx=00 err=0", bus.o_idx, bus.o_ERR);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_flip();
        int de, dc;
        logic [N-1:0] idx;
        logic err;
        logic [N-1:0] va [3] = '{8'h5A, 8'h00, 8'h01};
        logic [N-1:0] vb [3] = '{8'h5E, 8'h80, 8'h00};
        logic [N-1:0] ei [3] = '{8'h02, 8'h07, 8'h00};
        for (int i = 0; i < 3; i++) begin
            run_scan(va[i], vb[i], -1, '0, '0, de, dc, idx, err);
            checks++;
            if (de !== 9 || dc !== 1) begin
                failures++; $display("FAIL single_latency[%0d] got edge=%0d pulses=%0d exp edge=9 pulses=1", i, de, dc);
            end
            checks++;
            if (idx !== ei[i] || err !== 1'b0) begin
                failures++; $display("FAIL single_result[%0d] got idx=%h err=%b exp idx=%h err=0", i, idx, err, ei[i]);
            end
        end
    endtask

    task automatic test_no_diff();
        int de, dc;
        logic [N-1:0] idx;
        logic err;
        run_scan(8'h3C, 8'h3C, -1, '0, '0, de, dc, idx, err);
        checks++;
        if (de !== 9 || dc !== 1) begin
            failures++; $display("FAIL nodiff_latency got edge=%0d pulses=%0d exp edge=9 pulses=1", de, dc);
        end
        checks++;
        if (idx !== 8'h00 || err !== 1'b1) begin
            failures++; $display("FAIL nodiff_result got idx=%h err=%b exp idx=00 err=1", idx, err);
        end
    endtask

    task automatic test_multi_flip();
        int de, dc;
        logic [N-1:0] idx;
        logic err;
        run_scan(8'h00, 8'h03, -1, '0, '0, de, dc, idx, err);
        checks++;
        if (de !== DBL_EDGE || dc !== 1) begin
            failures++; $display("FAIL double_latency got edge=%0d pulses=%0d exp edge=%0d pulses=1", de, dc, DBL_EDGE);
        end
        checks++;
        if (idx !== 8'h00 || err !== 1'b1) begin
            failures++; $display("FAIL double_result got idx=%h err=%b exp idx=00 err=1", idx, err);
        end
        run_scan(8'h00, 8'hE0, -1, '0, '0, de, dc, idx, err);
        checks++;
        if (de !== TRIPLE_EDGE || idx !== 8'h00 || err !== 1'b1) begin
            failures++; $display("FAIL triple got edge=%0d idx=%h err=%b exp edge=%0d idx=00 err=1",
                                 de, idx, err, TRIPLE_EDGE);
        end
    endtask

    task automatic test_hold();
        int de, dc;
        logic [N-1:0] idx;
        logic err;
        run_scan(8'h5A, 8'h5E, -1, '0, '0, de, dc, idx, err);
        // Result must survive idle cycles and the start of the next scan.
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_a     = 8'h00;
        bus.i_b     = 8'h80;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        checks++;
        if (bus.o_busy !== 1'b1 || bus.o_idx !== 8'h02 || bus.o_ERR !== 1'b0) begin
            failures++; $display("FAIL hold got busy=%b idx=%h err=%b exp busy=1 idx=02 err=0",
                                 bus.o_busy, bus.o_idx, bus.o_ERR);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_idx !== 8'h07) begin
            failures++; $display("FAIL hold_next got busy=%b idx=%h exp busy=0 idx=07", bus.o_busy, bus.o_idx);
        end
    endtask

    task automatic test_reset_mid_scan();
        int de, dc;
        int early_done = 0;
        logic [N-1:0] idx;
        logic err;
        run_scan(8'h00, 8'h03, -1, '0, '0, de, dc, idx, err); // leaves o_ERR=1
        @(negedge clk);
        bus.i_start = 1'b1;
        bus.i_a     = 8'h5A;
        bus.i_b     = 8'h5E;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            if (e == 4) rst = 1'b1;
            @(posedge clk);
            #1;
            if (bus.o_done === 1'b1) early_done++;
        end
        rst = 1'b0;
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_done !== 1'b0 || bus.o_idx !== 8'h00 || bus.o_ERR !== 1'b0) begin
            failures++; $display("FAIL midreset_outputs got busy=%b done=%b idx=%h err=%b exp all 0",
                                 bus.o_busy, bus.o_done, bus.o_idx, bus.o_ERR);
        end
        repeat (10) begin
            @(posedge clk);
            #1;
            if (bus.o_done === 1'b1) early_done++;
        end
        checks++;
        if (early_done !== 0) begin
            failures++; $display("FAIL midreset_nodone got pulses=%0d exp 0", early_done);
        end
        run_scan(8'h5A, 8'h5E, -1, '0, '0, de, dc, idx, err);
        checks++;
        if (de !== 9 || dc !== 1 || idx !== 8'h02 || err !== 1'b0) begin
            failures++; $display("FAIL midreset_fresh got edge=%0d pulses=%0d idx=%h err=%b exp edge=9 pulses=1 idx=02 err=0",
                                 de, dc, idx, err);
        end
    endtask

    task automatic test_restart_ignored();
        int de, dc;
        logic [N-1:0] idx;
        logic err;
        run_scan(8'h5A, 8'h5E, 3, 8'h00, 8'h80, de, dc, idx, err);
        checks++;
        if (de !== 9 || dc !== 1) begin
            failures++; $display("FAIL restart_latency got edge=%0d pulses=%0d exp edge=9 pulses=1", de, dc);
        end
        checks++;
        if (idx !== 8'h02 || err !== 1'b0) begin
            failures++; $display("FAIL restart_result got idx=%h err=%b exp idx=02 err=0", idx, err);
        end
    endtask

    initial begin
        bus.i_start = 1'b0;
        bus.i_a     = '0;
        bus.i_b     = '0;
        test_reset();
        test_single_flip();
        test_no_diff();
        test_multi_flip();
        test_hold();
        test_reset_mid_scan();
        test_restart_ignored();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
